// File: rtl/counter_updown_prescaled.sv
// Up/down counter with upper limit, wrap/saturate bounds, parallel load and a clock prescaler.
// Output and Tc update one edge after a tick or load; free-running, with no backpressure.
module counter_updown_prescaled #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] LIMIT    = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk_50M,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_value,
  output logic [WIDTH-1:0] Output,
  output logic             Tc
);

  localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_nxt;
  logic             psc_last;
  logic             tick;
  logic [WIDTH-1:0] cnt_nxt;
  logic             term;
  logic [WIDTH-1:0] load_clamped;

  // With PRESCALE=1, PSC_LAST is 0 and psc never leaves 0, so tick reduces to En.
  assign psc_last = (psc == PSC_LAST);
  assign psc_nxt  = psc_last ? '0 : psc + PSC_W'(1);
  assign tick     = En && psc_last;

  assign load_clamped = (Load_value > LIMIT) ? LIMIT : Load_value;

  always_comb begin
    cnt_nxt = Output;
    term    = 1'b0;
    if (Up) begin
      if (Output == LIMIT) begin
        term    = 1'b1;
        cnt_nxt = SATURATE ? LIMIT : '0;
      end else begin
        cnt_nxt = Output + WIDTH'(1);
      end
    end else begin
      if (Output == '0) begin
        term    = 1'b1;
        cnt_nxt = SATURATE ? '0 : LIMIT;
      end else begin
        cnt_nxt = Output - WIDTH'(1);
      end
    end
  end

  // Load wins over a coincident tick; the discarded tick also restarts the prescaler.
  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      Output <= '0;
      psc    <= '0;
      Tc     <= 1'b0;
    end else if (Load) begin
      Output <= load_clamped;
      psc    <= '0;
      Tc     <= 1'b0;
    end else begin
      if (En) begin
        psc <= psc_nxt;
      end
      if (tick) begin
        Output <= cnt_nxt;
        Tc     <= term;
      end else begin
        Tc     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_updown_prescaled.sv
// Four counter configurations driven in lockstep; a reference model queues expected results per edge.
module tb_counter_updown_prescaled;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] lv;
  logic [3:0] cnt_o [N];
  logic       tc_o  [N];

  always #10 clk = ~clk;

  counter_updown_prescaled #(.WIDTH(4)) u_a (
    .clk_50M(clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .Load_value(lv), .Output(cnt_o[0]), .Tc(tc_o[0]));
  counter_updown_prescaled #(.WIDTH(4), .LIMIT(4'd9)) u_b (
    .clk_50M(clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .Load_value(lv), .Output(cnt_o[1]), .Tc(tc_o[1]));
  counter_updown_prescaled #(.WIDTH(4), .SATURATE(1'b1)) u_c (
    .clk_50M(clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .Load_value(lv), .Output(cnt_o[2]), .Tc(tc_o[2]));
  counter_updown_prescaled #(.WIDTH(4), .LIMIT(4'd9), .PRESCALE(5)) u_d (
    .clk_50M(clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .Load_value(lv), .Output(cnt_o[3]), .Tc(tc_o[3]));

  int lim [N] = '{15, 9, 15, 9};
  int ps  [N] = '{1, 1, 1, 5};
  bit sat [N] = '{0, 0, 1, 0};

  int m_cnt [N];
  int m_psc [N];
  bit m_tc  [N];

  typedef struct {
    int idx;
    int cnt;
    bit tc;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_psc[i] = 0;
      m_tc[i]  = 1'b0;
    end
  endtask

  // Next state of every model for one edge with the inputs currently driven.
  task automatic model_edge();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      m_tc[i] = 1'b0;
      if (load) begin
        m_cnt[i] = (int'(lv) > lim[i]) ? lim[i] : int'(lv);
        m_psc[i] = 0;
      end else if (en) begin
        if (m_psc[i] == ps[i] - 1) begin
          m_psc[i] = 0;
          if (up) begin
            if (m_cnt[i] == lim[i]) begin
              m_tc[i]  = 1'b1;
              m_cnt[i] = sat[i] ? lim[i] : 0;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end else begin
            if (m_cnt[i] == 0) begin
              m_tc[i]  = 1'b1;
              m_cnt[i] = sat[i] ? 0 : lim[i];
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
            end
          end
        end else begin
          m_psc[i] = m_psc[i] + 1;
        end
      end
      e.idx = i;
      e.cnt = m_cnt[i];
      e.tc  = m_tc[i];
      sbq.push_back(e);
    end
  endtask

  // Called on a falling edge: drive, predict, take the rising edge, compare, return on next falling edge.
  task automatic step(input bit e_in, input bit u_in, input bit l_in, input logic [3:0] v_in);
    exp_t e;
    en   = e_in;
    up   = u_in;
    load = l_in;
    lv   = v_in;
    model_edge();
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("u%0d_cnt", e.idx), 32'(cnt_o[e.idx]), 32'(e.cnt));
      check($sformatf("u%0d_tc", e.idx), 32'(tc_o[e.idx]), 32'(e.tc));
    end
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    up   = 1'b0;
    load = 1'b0;
    lv   = 4'd0;
    model_reset();
    #2 rst = 1'b0;
    #3;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_async_cnt%0d", i), 32'(cnt_o[i]), 32'd0);
      check($sformatf("rst_async_tc%0d", i), 32'(tc_o[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    check("rst_hold_cnt", 32'(cnt_o[0]), 32'd0);
    while ($time < 100) @(negedge clk);
    rst = 1'b1;

    // Default counter counting down from reset: 15 with Tc, down to 0, then wrap to 15.
    step(1, 0, 0, 4'd0);
    check("first_edge_15", 32'(cnt_o[0]), 32'd15);
    check("first_edge_tc", 32'(tc_o[0]), 32'd1);
    for (int k = 0; k < 16; k++) step(1, 0, 0, 4'd0);

    // Count up from 0; the LIMIT=9 counter wraps 9 -> 0, the saturating one climbs.
    step(1, 1, 1, 4'd0);
    for (int k = 0; k < 11; k++) step(1, 1, 0, 4'd0);

    // Saturating down to 0 and holding with repeated Tc, then reverse.
    step(1, 0, 1, 4'd2);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 4'd0);
    check("sat_hold_0", 32'(cnt_o[2]), 32'd0);
    check("sat_repulse", 32'(tc_o[2]), 32'd1);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 4'd0);

    // Prescaled counting with an enable gap mid-prescale.
    step(1, 1, 1, 4'd0);
    for (int k = 0; k < 7; k++) step(1, 1, 0, 4'd0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 4'd0);
    for (int k = 0; k < 8; k++) step(1, 1, 0, 4'd0);

    // Load above LIMIT clamps; load on a tick edge discards the tick.
    step(0, 1, 1, 4'd12);
    check("clamp_lim9", 32'(cnt_o[3]), 32'd9);
    check("noclamp_lim15", 32'(cnt_o[0]), 32'd12);
    for (int k = 0; k < 6 && m_psc[3] != ps[3] - 1; k++) step(1, 0, 0, 4'd0);
    step(1, 0, 1, 4'd3);
    check("load_on_tick", 32'(cnt_o[3]), 32'd3);
    check("load_on_tick_tc", 32'(tc_o[3]), 32'd0);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 4'd0);

    // Asynchronous reset between edges while at 7.
    step(1, 1, 1, 4'd7);
    #3 rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("midrst_cnt%0d", i), 32'(cnt_o[i]), 32'd0);
      check($sformatf("midrst_tc%0d", i), 32'(tc_o[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    check("midrst_hold", 32'(cnt_o[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 7; k++) step(1, 1, 0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
